// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared pipeline definitions for the hazard/sequencing controller:
//   state_t     - controller state encoding (2 bits)
//   stage_en_t  - stage register enable bundle, ordered PC, IF/ID, ID/EX,
//                 EX/MEM, MEM/WB (MSB first)
//   EN_*        - the enable patterns the controller can drive
//   REG_ZERO    - architectural register 0 (hard-wired zero, never a hazard)
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2,
        ST_STEP     = 2'd3
    } state_t;

    typedef struct packed {
        logic pc;
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } stage_en_t;

    localparam stage_en_t EN_ALL      = 5'b11111;
    localparam stage_en_t EN_NONE     = 5'b00000;
    // Load-use bubble: hold PC and IF/ID, let the load move on to MEM.
    localparam stage_en_t EN_LOAD_USE = 5'b00111;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   Pipeline -> controller: ID/EX register fields, branch/jump, memory
//                           handshake, debug pulses.
//   Controller -> pipeline: stage enables, flushes, status, event counters.
// Modports:
//   master - pipeline side (drives the hazard inputs)
//   slave  - controller side (hazard_ctrl)
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_jump;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             dbg_halt;
    logic             dbg_step;
    logic             dbg_resume;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_rt,
               ex_branch_taken, mem_req, mem_ready, dbg_halt, dbg_step, dbg_resume,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               halted, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_rt,
               ex_branch_taken, mem_req, mem_ready, dbg_halt, dbg_step, dbg_resume,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               halted, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Purely combinational: flags an instruction in ID that reads the register a
// load in EX is about to write.
//   i_id_rs, i_id_rt, i_id_uses_rt - source fields of the ID instruction
//   i_ex_mem_read, i_ex_rt         - load in EX and its destination
//   o_load_use                     - hazard present
// -----------------------------------------------------------------------------
module load_use_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_uses_rt,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rt,
    output logic       o_load_use
);
    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = (i_ex_rt == i_id_rs);
    assign w_rt_match = i_id_uses_rt && (i_ex_rt == i_id_rt);
    // r0 is never written, so a load targeting it cannot create a hazard.
    assign o_load_use = i_ex_mem_read && (i_ex_rt != REG_ZERO) && (w_rs_match || w_rt_match);
endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencing controller for the five-stage core. Drives stage
// enables/flushes for load-use stalls, branch/jump squashes and data-memory
// wait states, and runs a debug halt/single-step FSM plus saturating counters.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - hazard_ctrl_if slave modport (hazard inputs, enables, status)
// Enables and flushes are combinational from state and inputs; state,
// counters and mem_err are registered.
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset,
    hazard_ctrl_if.slave   bus
);
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_t             r_state;
    logic               r_halt_pend;   // leave MEM_WAIT into HALT instead of RUN
    logic               r_mem_err;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    logic               w_load_use;
    logic               w_mem_hold;
    logic               w_active;
    logic               w_squash;
    logic               w_stall;
    stage_en_t          w_en;
    logic               w_ifid_flush;
    logic               w_idex_flush;

    load_use_detect u_load_use_detect (
        .i_id_rs       (bus.id_rs),
        .i_id_rt       (bus.id_rt),
        .i_id_uses_rt  (bus.id_uses_rt),
        .i_ex_mem_read (bus.ex_mem_read),
        .i_ex_rt       (bus.ex_rt),
        .o_load_use    (w_load_use)
    );

    // Classify the current cycle: frozen by memory, frozen by debug, or
    // advancing (where squash/stall rules apply).
    always_comb begin
        w_mem_hold = 1'b0;
        case (r_state)
            ST_RUN, ST_STEP: w_mem_hold = bus.mem_req && !bus.mem_ready;
            ST_MEM_WAIT:     w_mem_hold = !bus.mem_ready;
            default:         w_mem_hold = 1'b0;
        endcase
        w_active = (r_state != ST_HALT) && !w_mem_hold;
        w_squash = w_active && (bus.ex_branch_taken || bus.id_jump);
        // A squash discards the dependent instruction, so no bubble is needed.
        w_stall  = w_active && !bus.ex_branch_taken && !bus.id_jump && w_load_use;
    end

    always_comb begin
        w_en         = EN_NONE;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        if (reset) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else if (w_active) begin
            if (bus.ex_branch_taken) begin
                w_en         = EN_ALL;
                w_ifid_flush = 1'b1;
                w_idex_flush = 1'b1;
            end else if (bus.id_jump) begin
                w_en         = EN_ALL;
                w_ifid_flush = 1'b1;
            end else if (w_load_use) begin
                w_en         = EN_LOAD_USE;
                w_idex_flush = 1'b1;
            end else begin
                w_en = EN_ALL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_halt_pend <= 1'b0;
            r_mem_err   <= 1'b0;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_squash && (r_flush_cnt != CNT_MAX)) r_flush_cnt <= r_flush_cnt + 1'b1;
            if (w_stall  && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + 1'b1;

            case (r_state)
                ST_RUN: begin
                    if (w_mem_hold) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= '0;
                        if (bus.dbg_halt) r_halt_pend <= 1'b1;
                    end else if (bus.dbg_halt || r_halt_pend) begin
                        r_state     <= ST_HALT;
                        r_halt_pend <= 1'b0;
                    end
                end
                ST_MEM_WAIT: begin
                    // Timeout only flags the error; the access keeps waiting.
                    if (r_wait_cnt == WAIT_MAX) r_mem_err  <= 1'b1;
                    else                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (bus.mem_ready) begin
                        if (r_halt_pend || bus.dbg_halt) begin
                            r_state     <= ST_HALT;
                            r_halt_pend <= 1'b0;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end else if (bus.dbg_halt) begin
                        r_halt_pend <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (bus.dbg_resume)    r_state <= ST_RUN;
                    else if (bus.dbg_step) r_state <= ST_STEP;
                end
                ST_STEP: begin
                    // A stepped instruction that stalls on memory finishes
                    // its access, then returns to HALT.
                    if (w_mem_hold) begin
                        r_state     <= ST_MEM_WAIT;
                        r_wait_cnt  <= '0;
                        r_halt_pend <= 1'b1;
                    end else begin
                        r_state <= ST_HALT;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign bus.pc_en      = w_en.pc;
    assign bus.ifid_en    = w_en.ifid;
    assign bus.idex_en    = w_en.idex;
    assign bus.exmem_en   = w_en.exmem;
    assign bus.memwb_en   = w_en.memwb;
    assign bus.ifid_flush = w_ifid_flush;
    assign bus.idex_flush = w_idex_flush;
    assign bus.halted     = (r_state == ST_HALT);
    assign bus.mem_err    = r_mem_err;
    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed stimulus for hazard_ctrl (CNT_W=4, MEM_TIMEOUT=2). A behavioural
// model tracks the controller from its rules and is compared against the DUT
// every cycle; literal checks pin key points of the sequence.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 2;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit m_valid, m_halted, m_waiting, m_stepping, m_halt_req, m_err;
    int m_wcyc, m_stall, m_flush;

    initial begin
        m_valid = 0; m_halted = 0; m_waiting = 0; m_stepping = 0;
        m_halt_req = 0; m_err = 0; m_wcyc = 0; m_stall = 0; m_flush = 0;
    end

    always @(negedge clk) begin
        bit       lu, busy, adv, br, jmp;
        bit [4:0] exp_en;
        bit       exp_iff, exp_idf;
        br   = bus.ex_branch_taken;
        jmp  = bus.id_jump;
        lu   = bus.ex_mem_read && (bus.ex_rt != 0) &&
               ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
        busy = m_waiting ? !bus.mem_ready : (!m_halted && bus.mem_req && !bus.mem_ready);
        adv  = !m_halted && !busy;
        exp_en = 5'b00000; exp_iff = 0; exp_idf = 0;
        if (reset) begin
            exp_iff = 1; exp_idf = 1;
        end else if (adv) begin
            if (br)       begin exp_en = 5'b11111; exp_iff = 1; exp_idf = 1; end
            else if (jmp) begin exp_en = 5'b11111; exp_iff = 1; end
            else if (lu)  begin exp_en = 5'b00111; exp_idf = 1; end
            else               exp_en = 5'b11111;
        end

        checks++;
        if ({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
             bus.ifid_flush, bus.idex_flush} !== {exp_en, exp_iff, exp_idf}) begin
            errors++;
            $display("FAIL en_flush t=%0t: got en=%b%b%b%b%b fl=%b%b want en=%b fl=%b%b", $time,
                     bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                     bus.ifid_flush, bus.idex_flush, exp_en, exp_iff, exp_idf);
        end
        if (m_valid) begin
            checks++;
            if ({bus.halted, bus.mem_err} !== {m_halted, m_err}) begin
                errors++;
                $display("FAIL status t=%0t: got halted=%b mem_err=%b want halted=%b mem_err=%b",
                         $time, bus.halted, bus.mem_err, m_halted, m_err);
            end
            checks++;
            if (bus.stall_cnt !== CNT_W'(m_stall) || bus.flush_cnt !== CNT_W'(m_flush)) begin
                errors++;
                $display("FAIL counters t=%0t: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                         $time, bus.stall_cnt, bus.flush_cnt, m_stall, m_flush);
            end
        end

        // Advance the model to the state after the coming clock edge.
        if (reset) begin
            m_valid = 1; m_halted = 0; m_waiting = 0; m_stepping = 0;
            m_halt_req = 0; m_err = 0; m_wcyc = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (adv && (br || jmp) && m_flush < CMAX) m_flush++;
            if (adv && !br && !jmp && lu && m_stall < CMAX) m_stall++;
            if (m_halted) begin
                if (bus.dbg_resume) m_halted = 0;
                else if (bus.dbg_step) begin m_halted = 0; m_stepping = 1; end
            end else if (m_waiting) begin
                if (m_wcyc == TIMEOUT) m_err = 1; else m_wcyc++;
                if (bus.mem_ready) begin
                    m_waiting  = 0;
                    m_halted   = m_halt_req || bus.dbg_halt;
                    m_halt_req = 0;
                end else if (bus.dbg_halt) m_halt_req = 1;
            end else if (busy) begin
                m_waiting = 1; m_wcyc = 0;
                if (m_stepping || bus.dbg_halt) m_halt_req = 1;
                m_stepping = 0;
            end else begin
                m_halted   = m_stepping || bus.dbg_halt || m_halt_req;
                m_stepping = 0; m_halt_req = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rt = 0; bus.id_jump = 0;
        bus.ex_mem_read = 0; bus.ex_rt = 0; bus.ex_branch_taken = 0;
        bus.mem_req = 0; bus.mem_ready = 0;
        bus.dbg_halt = 0; bus.dbg_step = 0; bus.dbg_resume = 0;
    endtask

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // End the current cycle: sample point then move just past the next edge.
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load_use(input logic [4:0] rs, input logic [4:0] rt,
                            input logic uses_rt, input logic [4:0] exrt);
        idle();
        bus.ex_mem_read = 1; bus.ex_rt = exrt;
        bus.id_rs = rs; bus.id_rt = rt; bus.id_uses_rt = uses_rt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0;
        reset = 1; idle();
        @(negedge clk);
        $display("txn reset");
        lit("rst_pc_en", bus.pc_en, 0);
        lit("rst_ifid_flush", bus.ifid_flush, 1);
        lit("rst_idex_flush", bus.idex_flush, 1);
        tick(); tick();
        reset = 0; idle();
        @(negedge clk); lit("idle_pc_en", bus.pc_en, 1); tick();

        $display("txn load-use rs match");
        load_use(5'd5, 5'd0, 0, 5'd5);
        @(negedge clk);
        lit("lu_pc_en", bus.pc_en, 0); lit("lu_ifid_en", bus.ifid_en, 0);
        lit("lu_idex_flush", bus.idex_flush, 1); lit("lu_idex_en", bus.idex_en, 1);
        tick(); idle();
        @(negedge clk); lit("lu_stall_cnt", bus.stall_cnt, 1); tick();

        $display("txn load to r0");
        load_use(5'd0, 5'd0, 1, 5'd0);
        @(negedge clk); lit("r0_pc_en", bus.pc_en, 1); lit("r0_idex_flush", bus.idex_flush, 0); tick();

        $display("txn load-use rt match / rt unused");
        load_use(5'd1, 5'd7, 1, 5'd7);
        @(negedge clk); lit("rt_pc_en", bus.pc_en, 0); tick();
        load_use(5'd1, 5'd7, 0, 5'd7);
        @(negedge clk); lit("rt_unused_pc_en", bus.pc_en, 1); tick();

        $display("txn branch over hazard");
        load_use(5'd5, 5'd0, 0, 5'd5); bus.ex_branch_taken = 1;
        @(negedge clk);
        lit("br_ifid_flush", bus.ifid_flush, 1); lit("br_idex_flush", bus.idex_flush, 1);
        lit("br_pc_en", bus.pc_en, 1);
        tick(); idle();
        @(negedge clk); lit("br_flush_cnt", bus.flush_cnt, 1); lit("br_stall_cnt", bus.stall_cnt, 2); tick();

        $display("txn jump");
        idle(); bus.id_jump = 1;
        @(negedge clk); lit("j_ifid_flush", bus.ifid_flush, 1); lit("j_idex_flush", bus.idex_flush, 0); tick();

        $display("txn memory wait 3 cycles");
        for (int i = 0; i < 3; i++) begin
            idle(); bus.mem_req = 1;
            @(negedge clk); lit("mw_pc_en", bus.pc_en, 0); lit("mw_memwb_en", bus.memwb_en, 0); tick();
        end
        idle(); bus.mem_req = 1; bus.mem_ready = 1;
        @(negedge clk); lit("mw_ready_memwb_en", bus.memwb_en, 1); lit("mw_err_early", bus.mem_err, 0); tick();
        idle();
        @(negedge clk); lit("mw_err", bus.mem_err, 1); lit("mw_halted", bus.halted, 0); tick();

        $display("txn halt / step / resume");
        idle(); bus.dbg_halt = 1;
        @(negedge clk); tick(); idle();
        @(negedge clk); lit("h_halted", bus.halted, 1); lit("h_pc_en", bus.pc_en, 0); tick();
        bus.dbg_step = 1;
        @(negedge clk); tick(); idle();
        @(negedge clk); lit("s_pc_en", bus.pc_en, 1); lit("s_halted", bus.halted, 0); tick();
        bus.dbg_step = 1; bus.dbg_resume = 1;
        @(negedge clk); lit("s_rehalted", bus.halted, 1); tick(); idle();
        @(negedge clk); lit("resume_halted", bus.halted, 0); tick();

        $display("txn halt during memory wait");
        idle(); bus.mem_req = 1;
        @(negedge clk); tick();
        bus.dbg_halt = 1;
        @(negedge clk); tick(); idle(); bus.mem_req = 1; bus.mem_ready = 1;
        @(negedge clk); lit("hw_ready_pc_en", bus.pc_en, 1); lit("hw_not_yet", bus.halted, 0); tick();
        idle(); bus.dbg_resume = 1;
        @(negedge clk); lit("hw_halted", bus.halted, 1); tick(); idle();
        @(negedge clk); tick();

        $display("txn step into memory wait");
        bus.dbg_halt = 1;
        @(negedge clk); tick(); idle(); bus.dbg_step = 1;
        @(negedge clk); tick(); idle(); bus.mem_req = 1;
        @(negedge clk); lit("sw_pc_en", bus.pc_en, 0); tick(); bus.mem_ready = 1;
        @(negedge clk); lit("sw_ready_pc_en", bus.pc_en, 1); tick(); idle(); bus.dbg_resume = 1;
        @(negedge clk); lit("sw_halted", bus.halted, 1); tick(); idle();
        @(negedge clk); tick();

        $display("txn reset mid-wait");
        idle(); bus.mem_req = 1;
        @(negedge clk); tick();
        @(negedge clk); tick();
        reset = 1;
        @(negedge clk); lit("rw_ifid_flush", bus.ifid_flush, 1); lit("rw_idex_flush", bus.idex_flush, 1); tick();
        reset = 0; idle();
        @(negedge clk);
        lit("rw_halted", bus.halted, 0); lit("rw_stall", bus.stall_cnt, 0);
        lit("rw_flush", bus.flush_cnt, 0); lit("rw_err", bus.mem_err, 0); lit("rw_pc_en", bus.pc_en, 1);
        tick();

        $display("txn saturation 20 stalls, 20 jumps");
        for (int i = 0; i < 20; i++) begin
            load_use(5'd9, 5'd0, 0, 5'd9);
            @(negedge clk); tick();
        end
        idle();
        @(negedge clk); lit("sat_stall", bus.stall_cnt, 15); tick();
        for (int i = 0; i < 20; i++) begin
            idle(); bus.id_jump = 1;
            @(negedge clk); tick();
        end
        idle();
        @(negedge clk); lit("sat_flush", bus.flush_cnt, 15); tick();

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
